// File: rtl/rvfi_pc_fwd_if.sv
// RVFI subset seen by the forward PC-chain checker: one slice per retire channel.
// The core/harness side drives through master; the checker observes through slave.
interface rvfi_pc_fwd_if #(
  parameter int unsigned NRET = 1,
  parameter int unsigned XLEN = 32
);
  logic [NRET-1:0]      rvfi_valid;
  logic [NRET*64-1:0]   rvfi_order;
  logic [NRET*XLEN-1:0] rvfi_pc_rdata;
  logic [NRET*XLEN-1:0] rvfi_pc_wdata;
  logic [NRET-1:0]      rvfi_intr;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_intr
  );

  modport slave (
    input rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_intr
  );
endinterface

// File: rtl/rvfi_pc_fwd_chain_check.sv
// Forward PC-chain checker: captures orders anchor..anchor+DEPTH-1 and checks that each
// pc_wdata matches the successor's pc_rdata. RISCV_FORMAL_PC_FWD_INTR_SKIP_EN exempts pairs
// whose successor is a trap entry (intr=1).
`ifndef RVFORMAL_ADDR_EQ
`define RVFORMAL_ADDR_EQ(a, b) ((a) == (b))
`endif

module rvfi_pc_fwd_chain_check #(
  parameter int unsigned NRET  = 1,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     check,
  // Order A; the formal harness ties this to a solver-chosen constant.
  input  logic [63:0]              anchor,
  rvfi_pc_fwd_if.slave             rvfi,
  output logic [1:0]               fwd_state,
  output logic [DEPTH-1:0]         fwd_captured,
  output logic [$clog2(DEPTH)-1:0] fwd_pairs,
  output logic                     fwd_mismatch
);
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle = 2'd0, StFill = 2'd1, StFull = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  captured_q, captured_d;
  logic [XLEN-1:0]   rdata_q [DEPTH];
  logic [XLEN-1:0]   rdata_d [DEPTH];
  logic [XLEN-1:0]   wdata_q [DEPTH];
  logic [XLEN-1:0]   wdata_d [DEPTH];
  logic [DEPTH-1:0]  intr_q, intr_d;
  logic [CntW-1:0]   pairs_q, pairs_d;
  logic              mismatch_q, mismatch_d;
  logic              mismatch_now;
  logic [63:0]       off;
  logic [IdxW-1:0]   idx;
  logic              exempt;

  always_comb begin
    rdata_d      = rdata_q;
    wdata_d      = wdata_q;
    intr_d       = intr_q;
    captured_d   = captured_q;
    pairs_d      = pairs_q;
    mismatch_now = 1'b0;
    off          = '0;
    idx          = '0;
    exempt       = 1'b0;

    // Scan order 0..NRET-1 so a lower channel wins a same-cycle duplicate.
    for (int c = 0; c < NRET; c++) begin
      off = rvfi.rvfi_order[c*64 +: 64] - anchor;
      idx = off[IdxW-1:0];
      if (rvfi.rvfi_valid[c] && (off < 64'(DEPTH)) && !captured_d[idx]) begin
        rdata_d[idx]    = rvfi.rvfi_pc_rdata[c*XLEN +: XLEN];
        wdata_d[idx]    = rvfi.rvfi_pc_wdata[c*XLEN +: XLEN];
        intr_d[idx]     = rvfi.rvfi_intr[c];
        captured_d[idx] = 1'b1;
      end
    end

    // A pair is compared only in the cycle it first becomes complete.
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (captured_d[i] && captured_d[i+1] && !(captured_q[i] && captured_q[i+1])) begin
        pairs_d = pairs_d + CntW'(1);
`ifdef RISCV_FORMAL_PC_FWD_INTR_SKIP_EN
        exempt = intr_d[i+1];
`else
        exempt = 1'b0;
`endif
        if (!exempt && !(`RVFORMAL_ADDR_EQ(wdata_d[i], rdata_d[i+1]))) begin
          mismatch_now = 1'b1;
        end
      end
    end

    mismatch_d = mismatch_q | mismatch_now;

    state_d = state_q;
    if (state_q != StFull) begin
      if (&captured_d) begin
        state_d = StFull;
      end else if (|captured_d) begin
        state_d = StFill;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      captured_q <= '0;
      intr_q     <= '0;
      pairs_q    <= '0;
      mismatch_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rdata_q[i] <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      captured_q <= captured_d;
      intr_q     <= intr_d;
      pairs_q    <= pairs_d;
      mismatch_q <= mismatch_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
    end
  end

  assign fwd_state    = state_q;
  assign fwd_captured = captured_q;
  assign fwd_pairs    = pairs_q;
  assign fwd_mismatch = mismatch_q;

`ifdef RISCV_FORMAL
  always_comb begin
    if (check) begin
      assume (state_q == StFull || (&captured_d));
      assert (!mismatch_q && !mismatch_now);
    end
  end
`else
  logic unused_check;
  assign unused_check = check;
`endif

endmodule

// File: tb/tb_rvfi_pc_fwd_chain_check.sv
// Directed bench for rvfi_pc_fwd_chain_check (NRET=2, XLEN=32, DEPTH=4) with an
// expected-result queue popped one cycle after each retire step.
module tb_rvfi_pc_fwd_chain_check;
  localparam int unsigned NRET  = 2;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [3:0] cap;
    logic [1:0] pairs;
    logic       mm;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        check = 1'b0;
  logic [63:0] anchor = 64'd10;
  logic [1:0]  fwd_state;
  logic [3:0]  fwd_captured;
  logic [1:0]  fwd_pairs;
  logic        fwd_mismatch;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb [$];

`ifdef RISCV_FORMAL_PC_FWD_INTR_SKIP_EN
  localparam logic IntrMm = 1'b0;
`else
  localparam logic IntrMm = 1'b1;
`endif

  rvfi_pc_fwd_if #(.NRET(NRET), .XLEN(XLEN)) rvfi ();

  rvfi_pc_fwd_chain_check #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .check        (check),
    .anchor       (anchor),
    .rvfi         (rvfi),
    .fwd_state    (fwd_state),
    .fwd_captured (fwd_captured),
    .fwd_pairs    (fwd_pairs),
    .fwd_mismatch (fwd_mismatch)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic retire(input int c, input logic [63:0] ord, input logic [31:0] rd,
                        input logic [31:0] wd, input logic intr);
    rvfi.rvfi_valid[c]               = 1'b1;
    rvfi.rvfi_order[c*64 +: 64]      = ord;
    rvfi.rvfi_pc_rdata[c*XLEN +: XLEN] = rd;
    rvfi.rvfi_pc_wdata[c*XLEN +: XLEN] = wd;
    rvfi.rvfi_intr[c]                = intr;
  endtask

  // Push the expectation, clock once, then pop and compare the registered outputs.
  task automatic tick(input string tag, input logic [1:0] st, input logic [3:0] cap,
                      input logic [1:0] pairs, input logic mm);
    exp_t e;
    e.tag = tag; e.st = st; e.cap = cap; e.pairs = pairs; e.mm = mm;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".state"},    32'(fwd_state),    32'(e.st));
    chk({e.tag, ".captured"}, 32'(fwd_captured), 32'(e.cap));
    chk({e.tag, ".pairs"},    32'(fwd_pairs),    32'(e.pairs));
    chk({e.tag, ".mismatch"}, 32'(fwd_mismatch), 32'(e.mm));
    rvfi.rvfi_valid = '0;
    rvfi.rvfi_intr  = '0;
    reset = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick(tag, 2'd0, 4'b0000, 2'd0, 1'b0);
  endtask

  initial begin
    rvfi.rvfi_valid    = '0;
    rvfi.rvfi_order    = '0;
    rvfi.rvfi_pc_rdata = '0;
    rvfi.rvfi_pc_wdata = '0;
    rvfi.rvfi_intr     = '0;
    #2;
    do_reset("rst0");

    // 1: clean chain on one channel.
    retire(0, 64'd10, 32'h100, 32'h104, 1'b0); tick("t1_o10", 2'd1, 4'b0001, 2'd0, 1'b0);
    retire(0, 64'd11, 32'h104, 32'h108, 1'b0); tick("t1_o11", 2'd1, 4'b0011, 2'd1, 1'b0);
    retire(0, 64'd12, 32'h108, 32'h10C, 1'b0); tick("t1_o12", 2'd1, 4'b0111, 2'd2, 1'b0);
    check = 1'b1;
    retire(0, 64'd13, 32'h10C, 32'h110, 1'b0); tick("t1_o13", 2'd2, 4'b1111, 2'd3, 1'b0);
    check = 1'b0;
    retire(0, 64'd14, 32'h110, 32'h114, 1'b0); tick("t1_o14", 2'd2, 4'b1111, 2'd3, 1'b0);
    do_reset("rst1");

    // 2: broken link between orders 11 and 12.
    retire(0, 64'd10, 32'h100, 32'h104, 1'b0); tick("t2_o10", 2'd1, 4'b0001, 2'd0, 1'b0);
    retire(0, 64'd11, 32'h104, 32'h108, 1'b0); tick("t2_o11", 2'd1, 4'b0011, 2'd1, 1'b0);
    retire(0, 64'd12, 32'h200, 32'h10C, 1'b0); tick("t2_o12", 2'd1, 4'b0111, 2'd2, 1'b1);
    retire(0, 64'd13, 32'h10C, 32'h110, 1'b0); tick("t2_o13", 2'd2, 4'b1111, 2'd3, 1'b1);
    do_reset("rst2");

    // 3: two channels, out-of-order within each cycle; order 9 sits below the window.
    retire(0, 64'd9,  32'h0FC, 32'h100, 1'b0); tick("t3_o9", 2'd0, 4'b0000, 2'd0, 1'b0);
    retire(0, 64'd11, 32'h104, 32'h108, 1'b0);
    retire(1, 64'd10, 32'h100, 32'h104, 1'b0); tick("t3_c1", 2'd1, 4'b0011, 2'd1, 1'b0);
    retire(0, 64'd13, 32'h10C, 32'h110, 1'b0);
    retire(1, 64'd12, 32'h108, 32'h10C, 1'b0); tick("t3_c2", 2'd2, 4'b1111, 2'd3, 1'b0);
    do_reset("rst3");

    // 4: window wrapping past 2^64-1; order 2 (offset 4) is outside.
    anchor = 64'hFFFF_FFFF_FFFF_FFFE;
    retire(0, 64'd2, 32'h110, 32'h114, 1'b0);
    tick("t4_out", 2'd0, 4'b0000, 2'd0, 1'b0);
    retire(0, 64'hFFFF_FFFF_FFFF_FFFE, 32'h100, 32'h104, 1'b0);
    tick("t4_m2", 2'd1, 4'b0001, 2'd0, 1'b0);
    retire(0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h104, 32'h108, 1'b0);
    tick("t4_m1", 2'd1, 4'b0011, 2'd1, 1'b0);
    retire(0, 64'd0, 32'h108, 32'h10C, 1'b0);
    retire(1, 64'd1, 32'h10C, 32'h110, 1'b0);
    tick("t4_01", 2'd2, 4'b1111, 2'd3, 1'b0);
    anchor = 64'd10;
    do_reset("rst4");

    // 5: successor of order 10 is a trap entry.
    retire(0, 64'd10, 32'h100, 32'h104, 1'b0);  tick("t5_o10", 2'd1, 4'b0001, 2'd0, 1'b0);
    retire(0, 64'd11, 32'h8000, 32'h8004, 1'b1); tick("t5_o11", 2'd1, 4'b0011, 2'd1, IntrMm);
    do_reset("rst5");

    // 6: mid-run reset, replay, and duplicates ignored (first write / lower channel wins).
    retire(0, 64'd10, 32'h100, 32'h104, 1'b0); tick("t6_o10", 2'd1, 4'b0001, 2'd0, 1'b0);
    retire(0, 64'd11, 32'h104, 32'h108, 1'b0); tick("t6_o11", 2'd1, 4'b0011, 2'd1, 1'b0);
    retire(0, 64'd12, 32'h108, 32'h10C, 1'b0);
    do_reset("t6_rst");
    retire(0, 64'd10, 32'h100, 32'h104, 1'b0); tick("t6_r10", 2'd1, 4'b0001, 2'd0, 1'b0);
    retire(0, 64'd11, 32'h104, 32'h108, 1'b0); tick("t6_r11", 2'd1, 4'b0011, 2'd1, 1'b0);
    retire(0, 64'd12, 32'h108, 32'h10C, 1'b0);
    retire(1, 64'd11, 32'h300, 32'h304, 1'b0); tick("t6_dup", 2'd1, 4'b0111, 2'd2, 1'b0);
    retire(0, 64'd13, 32'h10C, 32'h110, 1'b0);
    retire(1, 64'd13, 32'h500, 32'h504, 1'b0); tick("t6_r13", 2'd2, 4'b1111, 2'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
